// File: rtl/io_gpio_controller.sv
// Memory-mapped GPIO block: debounced switches with edge capture and maskable IRQ,
// byte-writable LEDs, and seven-segment digits in hex-decode or raw mode.
module io_gpio_controller #(
    parameter int NUM_SW       = 10,
    parameter int NUM_LED      = 9,
    parameter int NUM_HEX      = 6,
    parameter int DEBOUNCE_DIV = 50000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic                   Clock,
    input  logic                   Reset_L,
    input  logic                   IO_Select,
    input  logic                   AS_L,
    input  logic                   WE_L,
    input  logic [31:0]            Address,
    input  logic [3:0]             byte_enable,
    input  logic [31:0]            IO_data_in,
    output logic [31:0]            IO_data_out,
    input  logic [NUM_SW-1:0]      SW_input,
    output logic [NUM_LED-1:0]     LEDR_output,
    output logic [7*NUM_HEX-1:0]   HEX_output,
    output logic                   IRQ
);

    localparam int EW = (NUM_SW < 16) ? NUM_SW : 16;
    localparam int PW = (DEBOUNCE_DIV > 2) ? $clog2(DEBOUNCE_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DEBOUNCE_DIV - 1);
    localparam logic [3:0]    CNT_LAST = 4'(DEBOUNCE_CNT - 1);

    localparam logic [5:0] REG_SW    = 6'h00;
    localparam logic [5:0] REG_LEDR  = 6'h01;
    localparam logic [5:0] REG_HEXV  = 6'h02;
    localparam logic [5:0] REG_HEXC  = 6'h03;
    localparam logic [5:0] REG_EDGE  = 6'h04;
    localparam logic [5:0] REG_MASK  = 6'h05;
    localparam logic [5:0] REG_RAW0  = 6'h08;

    // Bus access detection
    logic        acc, acc_q, start, do_wr, do_rd;
    logic [5:0]  reg_idx;
    logic [31:0] wm;

    assign acc     = IO_Select & ~AS_L;
    assign start   = acc & ~acc_q;
    assign do_wr   = start & ~WE_L;
    assign do_rd   = start & WE_L;
    assign reg_idx = Address[7:2];
    assign wm      = {{8{byte_enable[3]}}, {8{byte_enable[2]}},
                      {8{byte_enable[1]}}, {8{byte_enable[0]}}};

    // acc_q resets high so an access still held across reset release needs a fresh start
    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) acc_q <= 1'b1;
        else          acc_q <= acc;
    end

    // Switch synchroniser, prescaler and per-bit debounce
    logic [NUM_SW-1:0] sync1, sync2, stable, accept;
    logic [PW-1:0]     pre;
    logic              tick;
    logic [3:0]        cnt [NUM_SW];

    assign tick = (pre == PRE_LAST);

    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            sync1 <= '0;
            sync2 <= '0;
            pre   <= '0;
        end else begin
            sync1 <= SW_input;
            sync2 <= sync1;
            pre   <= tick ? '0 : pre + 1'b1;
        end
    end

    always_comb begin
        accept = '0;
        for (int unsigned i = 0; i < NUM_SW; i++)
            accept[i] = tick && (sync2[i] != stable[i]) && (cnt[i] == CNT_LAST);
    end

    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            stable <= '0;
            for (int unsigned i = 0; i < NUM_SW; i++) cnt[i] <= '0;
        end else if (tick) begin
            for (int unsigned i = 0; i < NUM_SW; i++) begin
                if (sync2[i] != stable[i]) begin
                    if (accept[i]) begin
                        stable[i] <= sync2[i];
                        cnt[i]    <= '0;
                    end else begin
                        cnt[i]    <= cnt[i] + 4'd1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    // Register file
    logic [NUM_LED-1:0]   led_reg;
    logic [4*NUM_HEX-1:0] hex_value;
    logic                 raw_mode;
    logic [NUM_HEX-1:0]   hex_blank;
    logic [EW-1:0]        edge_rise, edge_fall, mask_rise, mask_fall;
    logic [EW-1:0]        rise_set, fall_set, clr_rise, clr_fall;
    logic [6:0]           hex_raw [NUM_HEX];
    logic [31:0]          rd_data;

    assign rise_set = accept[EW-1:0] & sync2[EW-1:0];
    assign fall_set = accept[EW-1:0] & ~sync2[EW-1:0];

    always_comb begin
        clr_rise = '0;
        clr_fall = '0;
        if (do_wr && reg_idx == REG_EDGE) begin
            clr_rise = IO_data_in[EW-1:0] & wm[EW-1:0];
            clr_fall = IO_data_in[16 +: EW] & wm[16 +: EW];
        end
    end

    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            led_reg     <= '0;
            hex_value   <= '0;
            raw_mode    <= 1'b0;
            hex_blank   <= '0;
            edge_rise   <= '0;
            edge_fall   <= '0;
            mask_rise   <= '0;
            mask_fall   <= '0;
            IO_data_out <= '0;
            IRQ         <= 1'b0;
            for (int unsigned i = 0; i < NUM_HEX; i++) hex_raw[i] <= 7'h7F;
        end else begin
            // Hardware set is OR'd after the W1C clear so a simultaneous new edge survives
            edge_rise <= (edge_rise & ~clr_rise) | rise_set;
            edge_fall <= (edge_fall & ~clr_fall) | fall_set;
            IRQ       <= |((edge_rise & mask_rise) | (edge_fall & mask_fall));
            if (do_rd) IO_data_out <= rd_data;
            if (do_wr) begin
                case (reg_idx)
                    REG_LEDR: led_reg <= (led_reg & ~wm[NUM_LED-1:0])
                                       | (IO_data_in[NUM_LED-1:0] & wm[NUM_LED-1:0]);
                    REG_HEXV: hex_value <= (hex_value & ~wm[4*NUM_HEX-1:0])
                                         | (IO_data_in[4*NUM_HEX-1:0] & wm[4*NUM_HEX-1:0]);
                    REG_HEXC: begin
                        if (byte_enable[0]) raw_mode <= IO_data_in[0];
                        if (byte_enable[1]) hex_blank <= IO_data_in[8 +: NUM_HEX];
                    end
                    REG_MASK: begin
                        mask_rise <= (mask_rise & ~wm[EW-1:0])
                                   | (IO_data_in[EW-1:0] & wm[EW-1:0]);
                        mask_fall <= (mask_fall & ~wm[16 +: EW])
                                   | (IO_data_in[16 +: EW] & wm[16 +: EW]);
                    end
                    default: begin
                        for (int unsigned i = 0; i < NUM_HEX; i++)
                            if (reg_idx == 6'(REG_RAW0 + i) && byte_enable[0])
                                hex_raw[i] <= IO_data_in[6:0];
                    end
                endcase
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (reg_idx)
            REG_SW:   rd_data = 32'(stable);
            REG_LEDR: rd_data = 32'(led_reg);
            REG_HEXV: rd_data = 32'(hex_value);
            REG_HEXC: begin
                rd_data[0]            = raw_mode;
                rd_data[8 +: NUM_HEX] = hex_blank;
            end
            REG_EDGE: begin
                rd_data[EW-1:0]  = edge_rise;
                rd_data[16 +: EW] = edge_fall;
            end
            REG_MASK: begin
                rd_data[EW-1:0]  = mask_rise;
                rd_data[16 +: EW] = mask_fall;
            end
            default: begin
                for (int unsigned i = 0; i < NUM_HEX; i++)
                    if (reg_idx == 6'(REG_RAW0 + i))
                        rd_data = {25'd0, hex_raw[i]};
            end
        endcase
    end

    // Seven-segment drive, active-low, bit0 = segment a
    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        HEX_output = '1;
        for (int unsigned i = 0; i < NUM_HEX; i++) begin
            if (hex_blank[i])  HEX_output[7*i +: 7] = 7'h7F;
            else if (raw_mode) HEX_output[7*i +: 7] = hex_raw[i];
            else               HEX_output[7*i +: 7] = seg7(hex_value[4*i +: 4]);
        end
    end

    assign LEDR_output = led_reg;

    logic unused_bits;
    assign unused_bits = ^{Address[31:8], Address[1:0], IO_data_in, wm, accept};

endmodule

// File: tb/tb_io_gpio_controller.sv
// Directed bench for io_gpio_controller with short debounce timing.
module tb_io_gpio_controller;

    logic        Clock = 1'b0;
    logic        Reset_L;
    logic        IO_Select, AS_L, WE_L;
    logic [31:0] Address;
    logic [3:0]  byte_enable;
    logic [31:0] IO_data_in;
    logic [31:0] IO_data_out;
    logic [9:0]  SW_input;
    logic [8:0]  LEDR_output;
    logic [41:0] HEX_output;
    logic        IRQ;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cyc;
    logic [31:0] rd;

    localparam logic [41:0] HEX_ZERO = {6{7'h40}};
    localparam logic [41:0] HEX_CDEF = {7'h40, 7'h40, 7'h46, 7'h21, 7'h06, 7'h0E};
    localparam logic [41:0] HEX_RAW1 = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h55};

    io_gpio_controller #(
        .NUM_SW(10), .NUM_LED(9), .NUM_HEX(6), .DEBOUNCE_DIV(4), .DEBOUNCE_CNT(3)
    ) dut (
        .Clock(Clock), .Reset_L(Reset_L), .IO_Select(IO_Select), .AS_L(AS_L), .WE_L(WE_L),
        .Address(Address), .byte_enable(byte_enable), .IO_data_in(IO_data_in),
        .IO_data_out(IO_data_out), .SW_input(SW_input), .LEDR_output(LEDR_output),
        .HEX_output(HEX_output), .IRQ(IRQ)
    );

    always #5 Clock = ~Clock;

    // Cycles since reset release; tick fires on the posedge after cyc % 4 == 3
    always @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge Clock);
        IO_Select = 1'b1; AS_L = 1'b0; WE_L = 1'b0;
        Address = a; IO_data_in = d; byte_enable = be;
        @(negedge Clock);
        IO_Select = 1'b0; AS_L = 1'b1; WE_L = 1'b1;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge Clock);
        IO_Select = 1'b1; AS_L = 1'b0; WE_L = 1'b1; Address = a;
        @(negedge Clock);
        d = IO_data_out;
        IO_Select = 1'b0; AS_L = 1'b1;
    endtask

    task automatic wait_phase3();
        do @(negedge Clock); while (cyc % 4 != 3);
    endtask

    initial begin
        Reset_L = 1'b0; IO_Select = 1'b0; AS_L = 1'b1; WE_L = 1'b1;
        Address = '0; byte_enable = '0; IO_data_in = '0; SW_input = '0;
        repeat (3) @(negedge Clock);
        Reset_L = 1'b1;
        repeat (2) @(negedge Clock);

        // Reset asserted in the middle of an LEDR write, strobe held across release
        @(negedge Clock);
        IO_Select = 1'b1; AS_L = 1'b0; WE_L = 1'b0;
        Address = 32'h04; IO_data_in = 32'h1FF; byte_enable = 4'hF;
        Reset_L = 1'b0;
        repeat (2) @(negedge Clock);
        Reset_L = 1'b1;
        repeat (3) @(negedge Clock);
        check("rst_led_held", LEDR_output, 9'h000);
        IO_Select = 1'b0; AS_L = 1'b1; WE_L = 1'b1;
        @(negedge Clock);
        check("rst_led", LEDR_output, 9'h000);
        check("rst_dout", IO_data_out, 32'h0);
        check("rst_irq", IRQ, 1'b0);
        check("rst_hex", HEX_output, HEX_ZERO);

        // Partial byte write to HEX_VALUE
        bus_write(32'h08, 32'h00ABCDEF, 4'b0011);
        check("hex_decode", HEX_output, HEX_CDEF);
        bus_read(32'h08, rd);
        check("rd_hexval", rd, 32'h0000CDEF);

        // Two-tick glitch rejected, sustained change accepted
        SW_input[0] = 1'b1;
        repeat (8) @(negedge Clock);
        SW_input[0] = 1'b0;
        repeat (16) @(negedge Clock);
        bus_read(32'h00, rd);
        check("glitch_sw", rd, 32'h0);
        bus_read(32'h10, rd);
        check("glitch_edge", rd, 32'h0);
        SW_input[0] = 1'b1;
        repeat (20) @(negedge Clock);
        bus_read(32'h00, rd);
        check("sw_data", rd, 32'h1);
        bus_read(32'h10, rd);
        check("sw_rise", rd, 32'h1);
        check("irq_masked", IRQ, 1'b0);

        // Interrupt masking and W1C
        bus_write(32'h10, 32'h1, 4'hF);
        bus_read(32'h10, rd);
        check("edge_clr", rd, 32'h0);
        bus_write(32'h14, 32'h1, 4'hF);
        SW_input[0] = 1'b0;
        repeat (20) @(negedge Clock);
        bus_read(32'h10, rd);
        check("sw_fall", rd, 32'h0001_0000);
        check("irq_fall_unmasked", IRQ, 1'b0);
        SW_input[0] = 1'b1;
        repeat (20) @(negedge Clock);
        check("irq_rise", IRQ, 1'b1);
        bus_write(32'h10, 32'h1, 4'hF);
        check("irq_reg_delay", IRQ, 1'b1);
        @(negedge Clock);
        check("irq_w1c", IRQ, 1'b0);

        // W1C landing on the same cycle as a new rise: set wins
        SW_input[0] = 1'b0;
        repeat (20) @(negedge Clock);
        wait_phase3();
        SW_input[0] = 1'b1;
        repeat (12) @(negedge Clock);
        IO_Select = 1'b1; AS_L = 1'b0; WE_L = 1'b0;
        Address = 32'h10; IO_data_in = 32'h1; byte_enable = 4'hF;
        @(negedge Clock);
        IO_Select = 1'b0; AS_L = 1'b1; WE_L = 1'b1;
        repeat (2) @(negedge Clock);
        check("irq_set_wins", IRQ, 1'b1);
        bus_read(32'h10, rd);
        check("edge_set_wins", rd, 32'h0001_0001);

        // Raw mode with blanking
        bus_write(32'h0C, 32'h201, 4'hF);
        bus_write(32'h20, 32'h55, 4'hF);
        check("hex_raw", HEX_output, HEX_RAW1);
        bus_read(32'h0C, rd);
        check("rd_hexctrl", rd, 32'h201);
        bus_read(32'h20, rd);
        check("rd_hexraw0", rd, 32'h55);
        bus_write(32'h0C, 32'h0, 4'hF);
        check("hex_back", HEX_output, HEX_CDEF);

        // Held strobe commits start-cycle data only
        @(negedge Clock);
        IO_Select = 1'b1; AS_L = 1'b0; WE_L = 1'b0;
        Address = 32'h04; IO_data_in = 32'h0AA; byte_enable = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            IO_data_in = 32'h155 + 32'(i);
        end
        @(negedge Clock);
        IO_Select = 1'b0; AS_L = 1'b1; WE_L = 1'b1;
        @(negedge Clock);
        check("held_strobe", LEDR_output, 9'h0AA);
        bus_write(32'h04, 32'h1FF, 4'b0010);
        check("led_be", LEDR_output, 9'h1AA);
        bus_read(32'h04, rd);
        check("rd_led", rd, 32'h1AA);

        // Unmapped, read-only and width boundaries
        bus_write(32'h3C, 32'hFFFF_FFFF, 4'hF);
        bus_read(32'h3C, rd);
        check("rd_unmapped", rd, 32'h0);
        bus_write(32'h00, 32'h0, 4'hF);
        bus_read(32'h00, rd);
        check("sw_ro", rd, 32'h1);
        bus_write(32'h14, 32'hFFFF_FFFF, 4'hF);
        bus_read(32'h14, rd);
        check("mask_width", rd, 32'h03FF_03FF);
        bus_write(32'h14, 32'h0, 4'hF);
        @(negedge Clock);
        check("dout_held", IO_data_out, 32'h03FF_03FF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
